// File: rtl/lcd_byte_writer_pkg.sv
// Shared definitions for the 4-bit HD44780 byte writer: default timings, command codes,
// FSM/phase encodings and the post-command wait selector.
package lcd_byte_writer_pkg;

  localparam int TIMER_W = 20;

  localparam int DEF_T_POWERUP = 750000;
  localparam int DEF_T_INIT1   = 205000;
  localparam int DEF_T_INIT2   = 5000;
  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_E_HIGH  = 12;
  localparam int DEF_T_NIB_GAP = 50;
  localparam int DEF_T_BYTE    = 2000;
  localparam int DEF_T_CLEAR   = 82000;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_FUNC_4BIT = 8'h28;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_SETUP,
    ST_EHIGH,
    ST_HOLD,
    ST_WAIT,
    ST_GAP,
    ST_IDLE
  } state_e;

  typedef enum logic [2:0] {
    PH_INIT0,
    PH_INIT1,
    PH_INIT2,
    PH_INIT3,
    PH_BYTE_HI,
    PH_BYTE_LO
  } phase_e;

  // Clear and return-home (0x02 and its don't-care twin 0x03) need the long settle time.
  function automatic logic needs_clear_wait(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter: loading N makes zero_o rise after exactly N cycles.
module lcd_delay_timer
  import lcd_byte_writer_pkg::*;
#(
  parameter int RST_LOAD = DEF_T_POWERUP
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               zero_o
);

  localparam logic [TIMER_W-1:0] RST_CNT = TIMER_W'(RST_LOAD - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i - TIMER_W'(1);
    end else if (count_q != '0) begin
      count_d = count_q - TIMER_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RST_CNT;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_byte_writer.sv
// HD44780 4-bit writer: power-on init nibbles, then one handshaked byte at a time.
// PWR_WAIT power-up delay | SETUP data/RS settle | EHIGH strobe | HOLD E low, bus held
// WAIT post-nibble/byte delay | GAP rest of inter-nibble gap | IDLE ready for a byte
module lcd_byte_writer
  import lcd_byte_writer_pkg::*;
#(
  parameter int T_POWERUP = DEF_T_POWERUP,
  parameter int T_INIT1   = DEF_T_INIT1,
  parameter int T_INIT2   = DEF_T_INIT2,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_E_HIGH  = DEF_T_E_HIGH,
  parameter int T_NIB_GAP = DEF_T_NIB_GAP,
  parameter int T_BYTE    = DEF_T_BYTE,
  parameter int T_CLEAR   = DEF_T_CLEAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic        wr_rs,
  input  logic [7:0]  wr_data,
  output logic        wr_ready,
  output logic        init_done,
  output logic [11:8] SF_D,
  output logic        LCD_E,
  output logic        LCD_RS,
  output logic        LCD_RW
);

  localparam int T_MAX = 2 ** TIMER_W - 1;

  if (T_POWERUP < 1 || T_INIT1 < 1 || T_INIT2 < 1 || T_SETUP < 1 || T_E_HIGH < 1 ||
      T_NIB_GAP < 1 || T_BYTE < 1 || T_CLEAR < 1) begin : g_bad_zero
    $error("lcd_byte_writer: timing parameters must all be >= 1");
  end
  if (T_POWERUP > T_MAX || T_INIT1 > T_MAX || T_INIT2 > T_MAX || T_E_HIGH > T_MAX ||
      T_NIB_GAP > T_MAX || T_BYTE > T_MAX || T_CLEAR > T_MAX) begin : g_bad_width
    $error("lcd_byte_writer: timing parameter exceeds the timer width");
  end
  if (T_NIB_GAP < T_SETUP + 2) begin : g_bad_gap
    $error("lcd_byte_writer: T_NIB_GAP must cover HOLD plus SETUP plus one cycle");
  end

  localparam logic [TIMER_W-1:0] L_SETUP  = TIMER_W'(T_SETUP);
  localparam logic [TIMER_W-1:0] L_E_HIGH = TIMER_W'(T_E_HIGH);
  localparam logic [TIMER_W-1:0] L_HOLD   = TIMER_W'(1);
  // Nibble gap is the full E-low time between strobes, so HOLD and SETUP come out of it.
  localparam logic [TIMER_W-1:0] L_GAP    = TIMER_W'(T_NIB_GAP - T_SETUP - 1);
  localparam logic [TIMER_W-1:0] L_INIT1  = TIMER_W'(T_INIT1);
  localparam logic [TIMER_W-1:0] L_INIT2  = TIMER_W'(T_INIT2);
  localparam logic [TIMER_W-1:0] L_BYTE   = TIMER_W'(T_BYTE);
  localparam logic [TIMER_W-1:0] L_CLEAR  = TIMER_W'(T_CLEAR);

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic [7:0]         data_q;
  logic               rs_byte_q;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic               tmr_zero;
  logic [TIMER_W-1:0] wait_len;
  logic               accept;
  logic               e_q, e_d;
  logic               rs_q, rs_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [3:0]         sfd_q, sfd_d;

  lcd_delay_timer #(
    .RST_LOAD(T_POWERUP)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .zero_o    (tmr_zero)
  );

  assign accept = wr_valid && ready_q;

  assign wait_len = (phase_q == PH_INIT0) ? L_INIT1 :
                    (phase_q == PH_INIT1) ? L_INIT2 :
                    (phase_q == PH_BYTE_LO && needs_clear_wait(rs_byte_q, data_q)) ? L_CLEAR :
                    L_BYTE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_PWR_WAIT;
      phase_q   <= PH_INIT0;
      data_q    <= '0;
      rs_byte_q <= 1'b0;
      e_q       <= 1'b0;
      rs_q      <= 1'b0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      sfd_q     <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      sfd_q   <= sfd_d;
      if (accept) begin
        data_q    <= wr_data;
        rs_byte_q <= wr_rs;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    tmr_load = 1'b0;
    tmr_val  = L_SETUP;
    unique case (state_q)
      ST_PWR_WAIT: begin
        if (tmr_zero) begin
          state_d  = ST_SETUP;
          phase_d  = PH_INIT0;
          tmr_load = 1'b1;
          tmr_val  = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_EHIGH;
          tmr_load = 1'b1;
          tmr_val  = L_E_HIGH;
        end
      end
      ST_EHIGH: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = L_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (phase_q == PH_BYTE_HI) begin
            state_d = ST_GAP;
            tmr_val = L_GAP;
          end else begin
            state_d = ST_WAIT;
            tmr_val = wait_len;
          end
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d  = ST_SETUP;
          phase_d  = PH_BYTE_LO;
          tmr_load = 1'b1;
          tmr_val  = L_SETUP;
        end
      end
      ST_WAIT: begin
        if (tmr_zero) begin
          if (phase_q == PH_INIT3 || phase_q == PH_BYTE_LO) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_SETUP;
            tmr_load = 1'b1;
            tmr_val  = L_SETUP;
            unique case (phase_q)
              PH_INIT0: phase_d = PH_INIT1;
              PH_INIT1: phase_d = PH_INIT2;
              default:  phase_d = PH_INIT3;
            endcase
          end
        end
      end
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_SETUP;
          phase_d  = PH_BYTE_HI;
          tmr_load = 1'b1;
          tmr_val  = L_SETUP;
        end
      end
      default: state_d = ST_PWR_WAIT;
    endcase
  end

  // Bus values change only on the edge that enters SETUP; the high nibble comes straight
  // from the accept-cycle inputs since the latch updates on that same edge.
  always_comb begin
    e_d     = (state_d == ST_EHIGH);
    ready_d = (state_d == ST_IDLE);
    done_d  = done_q || (state_d == ST_IDLE);
    sfd_d   = sfd_q;
    rs_d    = rs_q;
    if (state_d == ST_SETUP && state_q != ST_SETUP) begin
      unique case (phase_d)
        PH_INIT3: begin
          sfd_d = 4'h2;
          rs_d  = 1'b0;
        end
        PH_BYTE_HI: begin
          sfd_d = wr_data[7:4];
          rs_d  = wr_rs;
        end
        PH_BYTE_LO: begin
          sfd_d = data_q[3:0];
          rs_d  = rs_byte_q;
        end
        default: begin
          sfd_d = 4'h3;
          rs_d  = 1'b0;
        end
      endcase
    end
  end

  assign SF_D      = sfd_q;
  assign LCD_E     = e_q;
  assign LCD_RS    = rs_q;
  assign LCD_RW    = 1'b0;
  assign wr_ready  = ready_q;
  assign init_done = done_q;

endmodule
